// File: rtl/fifo_uart_sequencer.sv
// fifo_uart_sequencer: pops 16-bit samples from the FIFO and ships each one
// over the UART transmitter as an optional header byte plus two data bytes.
module fifo_uart_sequencer #(
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         GAP_CYCLES  = 16
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        freeze,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_q,
    output logic        fifo_rdreq,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LOAD,
        SEND,
        WHI,
        WLO,
        GAP
    } state_t;

    localparam logic [1:0] LAST_IDX = HEADER_EN ? 2'd2 : 2'd1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [15:0]   hold_q, hold_d;
    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rdreq_q, rdreq_d;
    logic          start_q, start_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic [15:0]   count_q, count_d;
    logic [7:0]    cur_byte;

    // Byte order on the wire: [header,] high byte, low byte.
    always_comb begin
        cur_byte = hold_q[7:0];
        if (HEADER_EN) begin
            unique case (idx_q)
                2'd0:    cur_byte = HEADER_BYTE;
                2'd1:    cur_byte = hold_q[15:8];
                default: cur_byte = hold_q[7:0];
            endcase
        end else begin
            cur_byte = (idx_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        rdreq_d = 1'b0;
        start_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                // tx_busy also covers a byte still draining after a reset
                if (enable && !freeze && !fifo_empty && !tx_busy) begin
                    rdreq_d = 1'b1;
                    state_d = RD;
                end
            end
            RD: state_d = LOAD;
            LOAD: begin
                hold_d  = fifo_q;
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                data_d  = cur_byte;
                start_d = 1'b1;
                state_d = WHI;
            end
            WHI: begin
                if (tx_busy)
                    state_d = WLO;
            end
            WLO: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = IDLE;
                else
                    gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            rdreq_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            rdreq_q <= rdreq_d;
            start_q <= start_d;
            data_q  <= data_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign fifo_rdreq  = rdreq_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_fifo_uart_sequencer.sv
// tb_fifo_uart_sequencer: scoreboard bench driving two sequencers, one with
// and one without the header byte, from shared enable/freeze/reset.
module tb_fifo_uart_sequencer;

    localparam int GAP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, freeze;
    logic [1:0]  fifo_empty, fifo_rdreq, tx_busy, tx_start, busy, frame_done;
    logic [15:0] fifo_q[2];
    logic [7:0]  tx_data[2];
    logic [15:0] frame_count[2];

    fifo_uart_sequencer #(
        .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5), .GAP_CYCLES(GAP)
    ) u0 (
        .mclk(clk), .rst(rst), .enable(enable), .freeze(freeze),
        .fifo_empty(fifo_empty[0]), .fifo_q(fifo_q[0]),
        .fifo_rdreq(fifo_rdreq[0]), .tx_busy(tx_busy[0]),
        .tx_start(tx_start[0]), .tx_data(tx_data[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .frame_count(frame_count[0])
    );

    fifo_uart_sequencer #(
        .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .GAP_CYCLES(GAP)
    ) u1 (
        .mclk(clk), .rst(rst), .enable(enable), .freeze(freeze),
        .fifo_empty(fifo_empty[1]), .fifo_q(fifo_q[1]),
        .fifo_rdreq(fifo_rdreq[1]), .tx_busy(tx_busy[1]),
        .tx_start(tx_start[1]), .tx_data(tx_data[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .frame_count(frame_count[1])
    );

    logic [15:0] fifo_m[2][$];
    logic [7:0]  exp_b[2][$];
    int          bcnt[2];
    int          uart_len;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_on = 1'b0;
    bit          in_fr[2], have_done[2], dvalid[2];
    int          seen[2], rd_cyc[2], done_cyc[2], st_cnt[2], rd_cnt[2];
    int          npush[2];
    logic [15:0] cnt_m[2];
    logic [7:0]  last_data[2];
    logic [7:0]  e;
    logic [1:0]  p_rdreq, p_start, p_done, p_busy, p_empty;
    logic        p_en, p_fz;

    assign tx_busy[0] = (bcnt[0] != 0);
    assign tx_busy[1] = (bcnt[1] != 0);

    function automatic void chk(bit ok, string name, int act, int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic int flen(int g);
        return (g == 0) ? 3 : 2;
    endfunction

    // Expected bytes are queued the moment a word enters the FIFO.
    task automatic push(int g, logic [15:0] w);
        fifo_m[g].push_back(w);
        if (g == 0)
            exp_b[g].push_back(8'hA5);
        exp_b[g].push_back(w[15:8]);
        exp_b[g].push_back(w[7:0]);
        npush[g]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO with one-cycle read latency and a UART busy for uart_len cycles.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (fifo_rdreq[g] && fifo_m[g].size() > 0)
                fifo_q[g] <= fifo_m[g].pop_front();
            fifo_empty[g] <= (fifo_m[g].size() == 0);
            if (tx_start[g])
                bcnt[g] <= uart_len;
            else if (bcnt[g] != 0)
                bcnt[g] <= bcnt[g] - 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            for (int g = 0; g < 2; g++) begin
                if (fifo_rdreq[g]) begin
                    rd_cnt[g]++;
                    chk(!p_rdreq[g], "rdreq_pulse", int'(p_rdreq[g]), 0);
                    chk(!in_fr[g], "rdreq_in_frame", int'(in_fr[g]), 0);
                    chk(p_en && !p_fz, "rdreq_gate", {p_en, p_fz}, 2);
                    chk(!p_empty[g], "rdreq_empty", int'(p_empty[g]), 0);
                    chk(!p_busy[g], "rdreq_tx_busy", int'(p_busy[g]), 0);
                    if (have_done[g])
                        chk(cyc - done_cyc[g] - 1 >= GAP, "gap",
                            cyc - done_cyc[g] - 1, GAP);
                    in_fr[g]  = 1'b1;
                    seen[g]   = 0;
                    rd_cyc[g] = cyc;
                end
                if (tx_start[g]) begin
                    st_cnt[g]++;
                    chk(!p_start[g], "start_pulse", int'(p_start[g]), 0);
                    chk(!tx_busy[g], "start_tx_busy", int'(tx_busy[g]), 0);
                    chk(in_fr[g] && busy[g], "start_in_frame",
                        int'(busy[g]), 1);
                    if (seen[g] == 0)
                        chk(cyc - rd_cyc[g] == 3, "latency",
                            cyc - rd_cyc[g], 3);
                    if (exp_b[g].size() == 0) begin
                        chk(1'b0, "extra_byte", int'(tx_data[g]), -1);
                    end else begin
                        e = exp_b[g].pop_front();
                        chk(tx_data[g] == e, (g == 0) ? "byte_hdr" : "byte_nohdr",
                            int'(tx_data[g]), int'(e));
                    end
                    seen[g]++;
                    last_data[g] = tx_data[g];
                    dvalid[g]    = 1'b1;
                end
                if (tx_busy[g] && dvalid[g])
                    chk(tx_data[g] == last_data[g], "data_stable",
                        int'(tx_data[g]), int'(last_data[g]));
                if (frame_done[g]) begin
                    chk(!p_done[g], "done_pulse", int'(p_done[g]), 0);
                    chk(in_fr[g] && seen[g] == flen(g), "done_bytes",
                        seen[g], flen(g));
                    chk(!tx_busy[g], "done_tx_busy", int'(tx_busy[g]), 0);
                    cnt_m[g]     = cnt_m[g] + 16'd1;
                    in_fr[g]     = 1'b0;
                    have_done[g] = 1'b1;
                    done_cyc[g]  = cyc;
                end
                chk(frame_count[g] == cnt_m[g], "frame_count",
                    int'(frame_count[g]), int'(cnt_m[g]));
            end
        end
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                // The popped word of an interrupted frame is never sent.
                if (in_fr[g])
                    repeat (flen(g) - seen[g])
                        if (exp_b[g].size() > 0)
                            void'(exp_b[g].pop_front());
                in_fr[g]     = 1'b0;
                seen[g]      = 0;
                have_done[g] = 1'b0;
                dvalid[g]    = 1'b0;
                cnt_m[g]     = 16'd0;
            end
        end
        p_rdreq = fifo_rdreq;
        p_start = tx_start;
        p_done  = frame_done;
        p_busy  = tx_busy;
        p_empty = fifo_empty;
        p_en    = enable;
        p_fz    = freeze;
    end

    task automatic wait_drain(int lim);
        int n = 0;
        while (!(exp_b[0].size() == 0 && exp_b[1].size() == 0 &&
                 fifo_m[0].size() == 0 && fifo_m[1].size() == 0 &&
                 !busy[0] && !busy[1]) && n < lim) begin
            tick();
            n++;
        end
        chk(n < lim, "drain_timeout", n, lim);
    endtask

    task automatic wait_starts(int target, int lim);
        int n = 0;
        while (st_cnt[0] < target && n < lim) begin
            tick();
            n++;
        end
        chk(n < lim, "start_timeout", n, lim);
    endtask

    task automatic check_reset(string tag);
        for (int g = 0; g < 2; g++) begin
            chk(!fifo_rdreq[g] && !tx_start[g] && !busy[g] && !frame_done[g],
                {tag, "_ctl"},
                {fifo_rdreq[g], tx_start[g], busy[g], frame_done[g]}, 0);
            chk(tx_data[g] == 8'h00, {tag, "_data"}, int'(tx_data[g]), 0);
            chk(frame_count[g] == 16'h0, {tag, "_count"},
                int'(frame_count[g]), 0);
        end
    endtask

    initial begin
        int b, n, r0, r1;
        rst      = 1'b1;
        enable   = 1'b0;
        freeze   = 1'b0;
        uart_len = 4;
        for (int g = 0; g < 2; g++) begin
            cnt_m[g] = 16'd0;
            bcnt[g]  = 0;
        end
        repeat (3) tick();
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check_reset("reset");

        // T1: one headed frame
        enable = 1'b1;
        push(0, 16'h1234);
        wait_drain(300);
        chk(frame_count[0] == 16'd1, "t1_count", int'(frame_count[0]), 1);
        chk(rd_cnt[0] == 1, "t1_rdreq", rd_cnt[0], 1);

        // T2: two back-to-back headerless frames
        push(1, 16'hBEEF);
        push(1, 16'h0001);
        wait_drain(400);
        chk(frame_count[1] == 16'd2, "t2_count", int'(frame_count[1]), 2);

        // T3: freeze holds off queued words, then mid-frame freeze
        freeze = 1'b1;
        r0 = rd_cnt[0];
        for (int i = 0; i < 3; i++)
            push(0, 16'($urandom));
        repeat (30) tick();
        chk(rd_cnt[0] == r0, "t3_frozen_rdreq", rd_cnt[0], r0);
        chk(!busy[0], "t3_frozen_busy", int'(busy[0]), 0);
        freeze = 1'b0;
        wait_drain(800);
        chk(frame_count[0] == 16'd4, "t3_count_a", int'(frame_count[0]), 4);
        push(0, 16'h0F0F);
        push(0, 16'hF0F0);
        b = st_cnt[0];
        wait_starts(b + 2, 300);
        freeze = 1'b1;
        n = 0;
        while (frame_count[0] != 16'd5 && n < 300) begin
            tick();
            n++;
        end
        chk(n < 300, "t3_done_timeout", n, 300);
        repeat (40) tick();
        chk(exp_b[0].size() == 3, "t3_next_held", exp_b[0].size(), 3);
        chk(!busy[0], "t3_held_busy", int'(busy[0]), 0);
        freeze = 1'b0;
        wait_drain(400);
        chk(frame_count[0] == 16'd6, "t3_count_b", int'(frame_count[0]), 6);

        // T4: reset while the second byte is on the wire
        uart_len = 10;
        push(0, 16'hCAFE);
        push(0, 16'h5A5A);
        b = st_cnt[0];
        wait_starts(b + 2, 300);
        n = 0;
        while (!tx_busy[0] && n < 50) begin
            tick();
            n++;
        end
        chk(n < 50, "t4_busy_timeout", n, 50);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        npush[0] = 1;
        npush[1] = 0;
        @(negedge clk);
        check_reset("t4_reset");
        wait_drain(600);
        chk(frame_count[0] == 16'd1, "t4_count", int'(frame_count[0]), 1);

        // T5: slow UART
        uart_len = 100;
        push(0, 16'($urandom));
        push(1, 16'($urandom));
        push(0, 16'hFFFF);
        wait_drain(3000);

        // T6: empty FIFO never pops
        uart_len = 2;
        r0 = rd_cnt[0];
        r1 = rd_cnt[1];
        repeat (50) tick();
        chk(rd_cnt[0] == r0 && rd_cnt[1] == r1, "t6_empty_rdreq",
            rd_cnt[0] + rd_cnt[1], r0 + r1);
        chk(busy == 2'b00, "t6_busy", int'(busy), 0);

        // Random traffic with enable/freeze and UART speed changes
        repeat (40) begin
            push($urandom_range(0, 1), 16'($urandom));
            enable   = ($urandom_range(0, 7) != 0);
            freeze   = ($urandom_range(0, 7) == 0);
            uart_len = $urandom_range(1, 6);
            repeat ($urandom_range(0, 25)) tick();
        end
        enable = 1'b1;
        freeze = 1'b0;
        wait_drain(4000);
        for (int g = 0; g < 2; g++)
            chk(frame_count[g] == 16'(npush[g]), "final_count",
                int'(frame_count[g]), npush[g]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
